// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit: FSM states,
// default halt encoding and the branch jump-target table.
package fetch_unit_pkg;

  localparam int unsigned INSTR_W = 9;
  localparam logic [INSTR_W-1:0] HALT_OP_DEFAULT = 9'h1FF;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_RUN   = 3'd2,
    ST_FLUSH = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

  // Entry i is the target for branch_idx == i (index 15 written first).
  localparam logic [15:0][7:0] JUMP_TABLE = {
    8'd136, 8'd128, 8'd120, 8'd112, 8'd104, 8'd96, 8'd88, 8'd80,
    8'd72,  8'd64,  8'd56,  8'd48,  8'd40,  8'd32, 8'd24, 8'd16
  };

endpackage

// File: rtl/fetch_unit_jump_lut.sv
// Combinational branch-target lookup: 4-bit index to a PC_W-bit target,
// zero-extended (or truncated for narrow PCs) from the shared table.
module jump_lut
  import fetch_unit_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic [3:0]      idx_i,
  output logic [PC_W-1:0] target_o
);

  logic [7:0] entry_s;

  assign entry_s = JUMP_TABLE[idx_i];

  generate
    if (PC_W > 8) begin : g_wide
      assign target_o = {{(PC_W-8){1'b0}}, entry_s};
    end else if (PC_W == 8) begin : g_exact
      assign target_o = entry_s;
    end else begin : g_narrow
      assign target_o = entry_s[PC_W-1:0];
    end
  endgenerate

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: sequential zero-bubble fetch from a one-cycle-latency
// memory, stall hold, one-bubble taken branches, halt detection and retire count.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                  PC_W    = 10,
  parameter logic [INSTR_W-1:0]  HALT_OP = HALT_OP_DEFAULT,
  parameter int                  CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [3:0]         branch_idx,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic [PC_W-1:0]    pc,
  output logic               done,
  output logic [CNT_W-1:0]   retired
);

  fetch_state_e     state_q, state_d;
  logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             done_q, done_d;
  logic [PC_W-1:0]  jump_target_s;

  jump_lut #(.PC_W(PC_W)) u_jump_lut (
    .idx_i    (branch_idx),
    .target_o (jump_target_s)
  );

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      fetch_pc_q <= '0;
      pc_q       <= '0;
      retired_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      retired_q  <= retired_d;
      done_q     <= done_d;
    end
  end

  // Next-state, fetch address and valid decode.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    pc_d        = pc_q;
    retired_d   = retired_q;
    done_d      = done_q;
    imem_addr   = '0;
    instr_valid = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d    = ST_FILL;
          fetch_pc_d = '0;
          retired_d  = '0;
          done_d     = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      // Bubble cycle: request fetch_pc now, it is displayed next cycle.
      ST_FILL, ST_FLUSH: begin
        imem_addr  = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + PC_W'(1);
        pc_d       = fetch_pc_q;
        state_d    = ST_RUN;
      end
      ST_RUN: begin
        instr_valid = 1'b1;
        if (stall) begin
          // Re-read the displayed address so instr stays stable.
          imem_addr = pc_q;
        end else begin
          imem_addr = fetch_pc_q;
          retired_d = (retired_q == {CNT_W{1'b1}}) ? retired_q : retired_q + CNT_W'(1);
          if (imem_rdata == HALT_OP) begin
            state_d = ST_HALT;
            done_d  = 1'b1;
          end else if (branch_taken) begin
            fetch_pc_d = jump_target_s;
            state_d    = ST_FLUSH;
          end else begin
            fetch_pc_d = fetch_pc_q + PC_W'(1);
            pc_d       = pc_q + PC_W'(1);
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign instr   = imem_rdata;
  assign pc      = pc_q;
  assign done    = done_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit: a default-width instance and a
// narrow instance (PC_W=4, CNT_W=3) for wrap and saturation.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic rst_n, start, stall, br, b_start;
  logic [3:0] idx;

  logic [9:0]  a_addr, a_pc;
  logic [8:0]  a_rdata, a_instr;
  logic        a_valid, a_done;
  logic [15:0] a_ret;

  logic [3:0]  b_addr, b_pc;
  logic [8:0]  b_rdata, b_instr;
  logic        b_valid, b_done;
  logic [2:0]  b_ret;

  logic [8:0] mem_a [1024];
  logic [8:0] mem_b [16];

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  always @(posedge clk) a_rdata <= mem_a[a_addr];
  always @(posedge clk) b_rdata <= mem_b[b_addr];

  fetch_unit dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .branch_taken(br), .branch_idx(idx), .imem_addr(a_addr),
    .imem_rdata(a_rdata), .instr(a_instr), .instr_valid(a_valid),
    .pc(a_pc), .done(a_done), .retired(a_ret)
  );

  fetch_unit #(.PC_W(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .stall(1'b0),
    .branch_taken(1'b0), .branch_idx(4'd0), .imem_addr(b_addr),
    .imem_rdata(b_rdata), .instr(b_instr), .instr_valid(b_valid),
    .pc(b_pc), .done(b_done), .retired(b_ret)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem_a[i] = 9'(i & 255);
    mem_a[7]  = 9'h1FF;
    mem_a[42] = 9'h1FF;
    for (int i = 0; i < 16; i++) mem_b[i] = 9'(i + 16);

    rst_n = 1'b0; start = 1'b0; stall = 1'b0; br = 1'b0; idx = 4'd0; b_start = 1'b0;
    #3;
    chk("rst_valid", a_valid, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_pc", a_pc, 0);
    chk("rst_done", a_done, 0);
    chk("rst_ret", a_ret, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    step(); step();
    chk("idle_valid", a_valid, 0);
    chk("idle_addr", a_addr, 0);

    // First run: fill, stall at pc 2, stalled branch at pc 5, halt at 42
    start = 1'b1; step(); start = 1'b0;
    chk("fill_valid", a_valid, 0);
    chk("fill_addr", a_addr, 0);
    step();
    chk("run0_valid", a_valid, 1);
    chk("run0_pc", a_pc, 0);
    chk("run0_instr", a_instr, 0);
    chk("run0_ret", a_ret, 0);
    step(); chk("run1_pc", a_pc, 1); chk("run1_instr", a_instr, 1);
    step(); chk("run2_pc", a_pc, 2);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("stall_pc", a_pc, 2);
      chk("stall_instr", a_instr, 2);
      chk("stall_ret", a_ret, 2);
      chk("stall_valid", a_valid, 1);
    end
    stall = 1'b0;
    step(); chk("resume_pc", a_pc, 3); chk("resume_instr", a_instr, 3); chk("resume_ret", a_ret, 3);
    step(); chk("run4_pc", a_pc, 4);
    step(); chk("run5_pc", a_pc, 5); chk("run5_ret", a_ret, 5);
    stall = 1'b1; br = 1'b1; idx = 4'd3;
    for (int k = 0; k < 2; k++) begin
      step();
      chk("brstall_pc", a_pc, 5);
      chk("brstall_valid", a_valid, 1);
      chk("brstall_ret", a_ret, 5);
    end
    stall = 1'b0;
    step();
    br = 1'b0;
    chk("flush_valid", a_valid, 0);
    chk("flush_ret", a_ret, 6);
    chk("flush_addr", a_addr, 40);
    step(); chk("tgt_pc", a_pc, 40); chk("tgt_instr", a_instr, 40); chk("tgt_valid", a_valid, 1);
    step(); chk("tgt1_pc", a_pc, 41);
    step(); chk("tgt2_pc", a_pc, 42); chk("tgt2_instr", a_instr, 9'h1FF);
    br = 1'b1;
    step();
    br = 1'b0;
    chk("halt1_done", a_done, 1);
    chk("halt1_valid", a_valid, 0);
    chk("halt1_ret", a_ret, 9);
    step();
    chk("halt1_hold_done", a_done, 1);
    chk("halt1_hold_valid", a_valid, 0);

    // Restart from HALT, start ignored mid-run, halt at pc 7
    start = 1'b1; step(); start = 1'b0;
    chk("restart_done", a_done, 0);
    chk("restart_ret", a_ret, 0);
    chk("restart_valid", a_valid, 0);
    for (int k = 0; k < 8; k++) begin
      step();
      start = 1'b0;
      chk("run2_pc_seq", a_pc, k);
      chk("run2_instr_seq", a_instr, (k == 7) ? 32'h1FF : k);
      chk("run2_ret_seq", a_ret, k);
      if (k == 3) start = 1'b1;
    end
    step();
    chk("halt2_done", a_done, 1);
    chk("halt2_valid", a_valid, 0);
    chk("halt2_ret", a_ret, 8);

    // Asynchronous reset while in FLUSH
    start = 1'b1; step(); start = 1'b0;
    step();
    br = 1'b1; idx = 4'd3;
    step();
    br = 1'b0;
    chk("pre_rst_valid", a_valid, 0);
    chk("pre_rst_addr", a_addr, 40);
    chk("pre_rst_ret", a_ret, 1);
    #2; rst_n = 1'b0; #2;
    chk("async_rst_addr", a_addr, 0);
    chk("async_rst_valid", a_valid, 0);
    chk("async_rst_pc", a_pc, 0);
    chk("async_rst_done", a_done, 0);
    chk("async_rst_ret", a_ret, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    step(); step();
    chk("post_rst_idle", a_valid, 0);

    // Narrow instance: wrap at 15 and retired saturation
    chk("b_idle_valid", b_valid, 0);
    b_start = 1'b1; step(); b_start = 1'b0;
    step();
    chk("b_run0_pc", b_pc, 0);
    chk("b_run0_valid", b_valid, 1);
    for (int k = 1; k <= 16; k++) begin
      step();
      chk("b_pc", b_pc, k % 16);
      chk("b_instr", b_instr, (k % 16) + 16);
      chk("b_ret", b_ret, (k > 7) ? 7 : k);
    end
    chk("b_done", b_done, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
